// File: rtl/bsg_rocket_pkg.sv
// Shared tunnel/FSB definitions for the rocket-side channel tunnel.
// Supplies default payload width, channel count and the wrap helper used by the arbiter.
package bsg_rocket_pkg;

    localparam int bsg_tun_dmx_width_p = 16;
    localparam int bsg_tun_num_in_p    = 2;

    typedef logic [bsg_tun_dmx_width_p-1:0] bsg_tun_dmx_t;

    typedef struct packed {
        logic                                 v;
        logic [$clog2(bsg_tun_num_in_p)-1:0]  id;
    } bsg_tun_dmx_ctrl_t;

    // Modulo-n wrap for an index that is known to be below 2*n.
    function automatic int bsg_tun_rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/bsg_tun_credit_counter.sv
// Per-channel credit counter: reloads to max_p on reset, saturates at 0 and max_p.
// A decrement and an increment in the same cycle cancel out.
module bsg_tun_credit_counter #(
    parameter  int max_p    = 128,
    localparam int width_lp = $clog2(max_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                dec_i,
    input  logic                inc_i,
    output logic [width_lp-1:0] count_o,
    output logic                nonzero_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_p);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= max_lp;
        end else if (inc_i && !dec_i && (count_o != max_lp)) begin
            count_o <= count_o + width_lp'(1);
        end else if (dec_i && !inc_i && (count_o != '0)) begin
            count_o <= count_o - width_lp'(1);
        end
    end

    assign nonzero_o = |count_o;

    // The remote end must never hand back more credits than it was given.
    always @(posedge clk_i) begin
        if (!reset_i && inc_i && !dec_i) begin
            assert (count_o != max_lp)
                else $warning("credit returned to a channel already at max_p");
        end
    end

endmodule

// File: rtl/bsg_tun_credit_rr_arbiter.sv
// Credit-gated round-robin scheduler sharing one tunnel link among num_in_p channels.
// Optional BSG_TUN_ARB_STATS_EN adds stall_cnt_o / starve_cnt_o performance counters.
module bsg_tun_credit_rr_arbiter
    import bsg_rocket_pkg::*;
#(
    parameter  int width_p          = bsg_tun_dmx_width_p,
    parameter  int num_in_p         = bsg_tun_num_in_p,
    parameter  int remote_credits_p = 128,
    localparam int id_w_lp          = $clog2(num_in_p),
    localparam int cnt_w_lp         = $clog2(remote_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_in_p-1:0]          v_i,
    input  logic [num_in_p*width_p-1:0]  data_i,
    output logic [num_in_p-1:0]          yumi_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [id_w_lp-1:0]           id_o,
    input  logic                         yumi_i,
    input  logic                         credit_v_i,
    input  logic [id_w_lp-1:0]           credit_id_i
`ifdef BSG_TUN_ARB_STATS_EN
    ,
    output logic [31:0]                  stall_cnt_o,
    output logic [31:0]                  starve_cnt_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e               state_r, state_n;
    logic [id_w_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic [id_w_lp-1:0]   lock_id_r, lock_id_n;
    logic [id_w_lp-1:0]   rr_grant, grant;
    logic                 rr_found, xfer;
    int                   rr_idx;
    logic [num_in_p-1:0]  eligible, nonzero, dec, inc;
    logic [cnt_w_lp-1:0]  credit [num_in_p];

    for (genvar g = 0; g < num_in_p; g++) begin : g_ch
        assign dec[g]      = xfer & (grant == id_w_lp'(g));
        assign inc[g]      = credit_v_i & (credit_id_i == id_w_lp'(g));
        assign eligible[g] = v_i[g] & nonzero[g];

        bsg_tun_credit_counter #(.max_p(remote_credits_p)) u_cnt (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .dec_i     (dec[g]),
            .inc_i     (inc[g]),
            .count_o   (credit[g]),
            .nonzero_o (nonzero[g])
        );
    end

    // First eligible channel at or after rr_ptr, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = 0;
        for (int i = 0; i < num_in_p; i++) begin
            rr_idx = bsg_tun_rr_wrap(int'(rr_ptr_r) + i, num_in_p);
            if (!rr_found && eligible[id_w_lp'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_grant = id_w_lp'(rr_idx);
            end
        end
    end

    // A locked grant ignores credit state; it already held a credit when it was chosen.
    always_comb begin
        grant  = (state_r == LOCKED) ? lock_id_r : rr_grant;
        v_o    = 1'b0;
        id_o   = '0;
        data_o = '0;
        yumi_o = '0;
        if (!reset_i) begin
            v_o  = (state_r == LOCKED) ? v_i[lock_id_r] : rr_found;
            id_o = grant;
            for (int i = 0; i < num_in_p; i++) begin
                if (grant == id_w_lp'(i)) begin
                    data_o = data_i[i*width_p +: width_p];
                end
            end
        end
        xfer = v_o & yumi_i;
        if (xfer) begin
            yumi_o[grant] = 1'b1;
        end
    end

    always_comb begin
        state_n   = state_r;
        lock_id_n = lock_id_r;
        rr_ptr_n  = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (v_o && !yumi_i) begin
                    state_n   = LOCKED;
                    lock_id_n = rr_grant;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (xfer) begin
            rr_ptr_n = (grant == id_w_lp'(num_in_p - 1)) ? '0 : grant + id_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            lock_id_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            state_r   <= state_n;
            lock_id_r <= lock_id_n;
            rr_ptr_r  <= rr_ptr_n;
        end
    end

`ifdef BSG_TUN_ARB_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_o  <= '0;
            starve_cnt_o <= '0;
        end else begin
            if (v_o && !yumi_i) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if ((|v_i) && !v_o) begin
                starve_cnt_o <= starve_cnt_o + 32'd1;
            end
        end
    end
`endif

    // Protocol checks; illegal inputs are otherwise ignored by the logic above.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $warning("yumi_i asserted without v_o");
            assert (!credit_v_i || (32'(credit_id_i) < 32'(num_in_p)))
                else $warning("credit_id_i out of range");
            assert ((state_r != LOCKED) || (credit[lock_id_r] != '0))
                else $warning("locked grant holds no credit");
        end
    end

endmodule

// File: tb/tb_bsg_tun_credit_rr_arbiter.sv
// Scoreboard bench for bsg_tun_credit_rr_arbiter (2 channels, 16-bit payload, 128 credits).
// Directed stimulus pushes expected transfers; a negedge monitor pops and compares them.
module tb_bsg_tun_credit_rr_arbiter;

    localparam int W = 16;
    localparam int N = 2;

    typedef struct packed {
        logic          id;
        logic [W-1:0]  data;
    } xfer_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    v_i;
    logic [N*W-1:0]  data_i;
    logic [N-1:0]    yumi_o;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic            id_o;
    logic            yumi_i;
    logic            credit_v_i;
    logic            credit_id_i;
`ifdef BSG_TUN_ARB_STATS_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     starve_cnt;
`endif

    logic [W-1:0]    d0, d1;
    xfer_t           exp_q[$];
    xfer_t           mon_e;
    int              vectors = 0;
    int              miscompares = 0;
    logic            pending = 1'b0;
    logic            pend_ch = 1'b0;

    assign data_i = {d1, d0};

    always #5 clk = ~clk;

    bsg_tun_credit_rr_arbiter #(
        .width_p(W), .num_in_p(N), .remote_credits_p(128)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .v_i         (v_i),
        .data_i      (data_i),
        .yumi_o      (yumi_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .id_o        (id_o),
        .yumi_i      (yumi_i),
        .credit_v_i  (credit_v_i),
        .credit_id_i (credit_id_i)
`ifdef BSG_TUN_ARB_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .starve_cnt_o(starve_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic y, input logic cv, input logic cid);
        v_i         = v;
        yumi_i      = y;
        credit_v_i  = cv;
        credit_id_i = cid;
    endtask

    // One clock cycle: refresh the payload of the channel that just transferred,
    // drive inputs, check combinational outputs and queue any expected transfer.
    task automatic cycle(input string name, input logic [1:0] v, input logic y,
                         input logic cv, input logic cid, input logic exp_v, input logic exp_id);
        logic [1:0] exp_yumi;
        @(posedge clk);
        #1;
        if (pending) begin
            if (pend_ch) d1 = d1 + 16'd1;
            else         d0 = d0 + 16'd1;
            pending = 1'b0;
        end
        applyStimulus(v, y, cv, cid);
        #1;
        exp_yumi = (exp_v && y) ? (exp_id ? 2'b10 : 2'b01) : 2'b00;
        checkOutput({name, " v_o"}, 32'(v_o), 32'(exp_v));
        checkOutput({name, " yumi_o"}, 32'(yumi_o), 32'(exp_yumi));
        if (exp_v) begin
            checkOutput({name, " id_o"}, 32'(id_o), 32'(exp_id));
            checkOutput({name, " data_o"}, 32'(data_o), 32'(exp_id ? d1 : d0));
            if (y) begin
                exp_q.push_back(xfer_t'{id: exp_id, data: (exp_id ? d1 : d0)});
                pending = 1'b1;
                pend_ch = exp_id;
            end
        end
    endtask

    task automatic checkCredits(input string name, input int c0, input int c1);
        checkOutput({name, " credit0"}, 32'(dut.g_ch[0].u_cnt.count_o), 32'(c0));
        checkOutput({name, " credit1"}, 32'(dut.g_ch[1].u_cnt.count_o), 32'(c1));
    endtask

    always @(negedge clk) begin
        if (!reset && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_xfer: got id %0d data %0h expected none", id_o, data_o);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("mon id", 32'(id_o), 32'(mon_e.id));
                checkOutput("mon data", 32'(data_o), 32'(mon_e.data));
            end
        end
    end

    initial begin
        reset = 1'b1;
        d0 = 16'hA000;
        d1 = 16'hB000;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        v_i = 2'b11;
        #1;
        checkOutput("reset v_o", 32'(v_o), 32'd0);
        checkOutput("reset yumi_o", 32'(yumi_o), 32'd0);
        checkOutput("reset id_o", 32'(id_o), 32'd0);
        checkOutput("reset data_o", 32'(data_o), 32'd0);
        checkCredits("reset", 128, 128);
        v_i = 2'b00;
        #1;
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            cycle("fair", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'(k % 2));
        end
        cycle("fair_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCredits("fair", 125, 125);

        cycle("lock_grant", 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("lock_hold1", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("lock_hold2", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("lock_rel", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("after_lock", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        cycle("simul", 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("simul_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCredits("simul", 124, 124);

        for (int k = 0; k < 4; k++) cycle("ret0", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle("ret1", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("ret_extra", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("ret_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCredits("saturate", 128, 128);

        for (int k = 0; k < 128; k++) cycle("exhaust", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("starved", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCredits("starved", 0, 128);
        cycle("skip_starved", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("return", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("revived", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("locked", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset v_o", 32'(v_o), 32'd0);
        checkOutput("mid_reset yumi_o", 32'(yumi_o), 32'd0);
        checkOutput("mid_reset rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
        checkOutput("mid_reset lock", 32'(dut.state_r), 32'd0);
        checkCredits("mid_reset", 128, 128);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("post_reset", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("post_reset2", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("final_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
